// File: rtl/lb_frame_tx.sv
// rtl/lb_frame_tx.sv - Ethernet/IPv4 frame builder streaming one inference packet as AXI-Stream bytes
// Latches addressing and payload on start, computes the IPv4 header checksum, then emits the packet.
module lb_frame_tx #(
    parameter logic [7:0] IP_TTL        = 8'h40,
    parameter logic [7:0] IP_PROTO      = 8'hFD,
    parameter int         PAYLOAD_BYTES = 785
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  SRC_IP_ADDRESS,
    input  logic [47:0]                  SRC_MAC_ADDRESS,
    input  logic [31:0]                  DEST_IP_ADDRESS,
    input  logic [47:0]                  DEST_MAC_ADDRESS,
    input  logic [PAYLOAD_BYTES*8-1:0]   DATA_FRAME,
    input  logic                         START_FRAME_TXN,
    output logic                         READY_FOR_SEND,
    output logic [7:0]                   TX_AXIS_TDATA,
    output logic                         TX_AXIS_TVALID,
    output logic                         TX_AXIS_TLAST,
    input  logic                         TX_AXIS_TREADY,
    output logic [15:0]                  FRAMES_SENT
);
    localparam int              TOTAL_BYTES = 34 + PAYLOAD_BYTES;
    localparam int              CW          = $clog2(TOTAL_BYTES);
    localparam logic [CW-1:0]   LAST_IDX    = CW'(TOTAL_BYTES - 1);
    localparam logic [15:0]     TOTAL_LEN   = 16'(20 + PAYLOAD_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_CSUM, ST_SEND} state_t;

    state_t                     state_q, state_d;
    logic [31:0]                src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [47:0]                src_mac_q, src_mac_d, dst_mac_q, dst_mac_d;
    logic [PAYLOAD_BYTES*8-1:0] frame_q, frame_d;
    logic [15:0]                ip_id_q, ip_id_d, csum_q, csum_d, frames_q, frames_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [7:0]                 tdata_q, tdata_d;
    logic                       tvalid_q, tvalid_d, tlast_q, tlast_d;

    logic [271:0]               hdr;
    logic [CW-1:0]              sel_idx, pidx;
    logic [5:0]                 hidx;
    logic [7:0]                 sel_byte;
    logic [19:0]                sum;
    logic [16:0]                fold1;
    logic [15:0]                fold2;

    always_comb begin
        state_d   = state_q;
        src_ip_d  = src_ip_q;
        dst_ip_d  = dst_ip_q;
        src_mac_d = src_mac_q;
        dst_mac_d = dst_mac_q;
        frame_d   = frame_q;
        ip_id_d   = ip_id_q;
        csum_d    = csum_q;
        frames_d  = frames_q;
        cnt_d     = cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;

        hdr = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, TOTAL_LEN, ip_id_q,
               16'h4000, IP_TTL, IP_PROTO, csum_q, src_ip_q, dst_ip_q};

        // Output bytes are registered, so the mux looks one byte ahead of the presented one.
        sel_idx = tvalid_q ? (cnt_q + CW'(1)) : '0;
        hidx    = 6'd33 - sel_idx[5:0];
        pidx    = sel_idx - CW'(34);
        if (sel_idx < CW'(34)) begin
            sel_byte = hdr[{hidx, 3'b000} +: 8];
        end else begin
            sel_byte = frame_q[{pidx, 3'b000} +: 8];
        end

        sum = 20'(16'h4500) + 20'(TOTAL_LEN) + 20'(ip_id_q) + 20'(16'h4000)
            + 20'({IP_TTL, IP_PROTO}) + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
            + 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
        fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);

        case (state_q)
            ST_IDLE: begin
                if (START_FRAME_TXN) begin
                    src_ip_d  = SRC_IP_ADDRESS;
                    dst_ip_d  = DEST_IP_ADDRESS;
                    src_mac_d = SRC_MAC_ADDRESS;
                    dst_mac_d = DEST_MAC_ADDRESS;
                    frame_d   = DATA_FRAME;
                    state_d   = ST_CSUM;
                end
            end
            ST_CSUM: begin
                csum_d  = ~fold2;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    cnt_d    = '0;
                    tdata_d  = sel_byte;
                    tlast_d  = (LAST_IDX == '0);
                end else if (TX_AXIS_TREADY) begin
                    if (cnt_q == LAST_IDX) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'h00;
                        cnt_d    = '0;
                        frames_d = frames_q + 16'd1;
                        ip_id_d  = ip_id_q + 16'd1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d   = sel_idx;
                        tdata_d = sel_byte;
                        tlast_d = (sel_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            src_ip_q  <= '0;
            dst_ip_q  <= '0;
            src_mac_q <= '0;
            dst_mac_q <= '0;
            frame_q   <= '0;
            ip_id_q   <= '0;
            csum_q    <= '0;
            frames_q  <= '0;
            cnt_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ip_q  <= src_ip_d;
            dst_ip_q  <= dst_ip_d;
            src_mac_q <= src_mac_d;
            dst_mac_q <= dst_mac_d;
            frame_q   <= frame_d;
            ip_id_q   <= ip_id_d;
            csum_q    <= csum_d;
            frames_q  <= frames_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    assign READY_FOR_SEND = (state_q == ST_IDLE);
    assign TX_AXIS_TDATA  = tdata_q;
    assign TX_AXIS_TVALID = tvalid_q;
    assign TX_AXIS_TLAST  = tlast_q;
    assign FRAMES_SENT    = frames_q;
endmodule

// File: tb/tb_lb_frame_tx.sv
// tb/tb_lb_frame_tx.sv - self-checking bench for lb_frame_tx against a byte-level packet model
module tb_lb_frame_tx;
    localparam int PB = 785;
    localparam int NB = 34 + PB;

    logic          aclk = 1'b0;
    logic          areset;
    logic [31:0]   src_ip, dst_ip;
    logic [47:0]   src_mac, dst_mac;
    logic [PB*8-1:0] data_frame;
    logic          start, tready;
    logic          ready, tvalid, tlast;
    logic [7:0]    tdata;
    logic [15:0]   frames;

    int            checks = 0;
    int            failures = 0;
    logic [15:0]   exp_id = 16'd0;
    logic [15:0]   exp_frames = 16'd0;
    logic [7:0]    exp_b   [0:NB-1];
    logic [7:0]    cap     [0:NB-1];
    logic [7:0]    ref_pkt [0:NB-1];
    logic [PB*8-1:0] saved_frame;
    logic [47:0]   saved_smac, saved_dmac;

    always #5 aclk = ~aclk;

    lb_frame_tx dut (
        .ACLK(aclk), .ARESET(areset),
        .SRC_IP_ADDRESS(src_ip), .SRC_MAC_ADDRESS(src_mac),
        .DEST_IP_ADDRESS(dst_ip), .DEST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(data_frame), .START_FRAME_TXN(start),
        .READY_FOR_SEND(ready), .TX_AXIS_TDATA(tdata), .TX_AXIS_TVALID(tvalid),
        .TX_AXIS_TLAST(tlast), .TX_AXIS_TREADY(tready), .FRAMES_SENT(frames)
    );

    // Packet model: lay out bytes in wire order, then checksum the header as 16-bit words.
    function automatic void build_expected(input logic [15:0] id);
        int unsigned s;
        logic [15:0] cs;
        for (int i = 0; i < 6; i++) begin
            exp_b[i]     = dst_mac[47-8*i -: 8];
            exp_b[6+i]   = src_mac[47-8*i -: 8];
        end
        exp_b[12] = 8'h08; exp_b[13] = 8'h00; exp_b[14] = 8'h45; exp_b[15] = 8'h00;
        exp_b[16] = 8'((20 + PB) >> 8); exp_b[17] = 8'((20 + PB) & 255);
        exp_b[18] = id[15:8]; exp_b[19] = id[7:0];
        exp_b[20] = 8'h40; exp_b[21] = 8'h00; exp_b[22] = 8'h40; exp_b[23] = 8'hFD;
        exp_b[24] = 8'h00; exp_b[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_b[26+i] = src_ip[31-8*i -: 8];
            exp_b[30+i] = dst_ip[31-8*i -: 8];
        end
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'h0, exp_b[14+2*w], exp_b[15+2*w]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        exp_b[24] = cs[15:8]; exp_b[25] = cs[7:0];
        for (int k = 0; k < PB; k++) exp_b[34+k] = data_frame[8*k +: 8];
    endfunction

    task automatic randomize_inputs();
        src_ip  = $urandom; dst_ip = $urandom;
        src_mac = {16'($urandom), 32'($urandom)};
        dst_mac = {16'($urandom), 32'($urandom)};
        for (int k = 0; k < PB; k++) data_frame[8*k +: 8] = 8'($urandom);
    endtask

    task automatic pulse_reset();
        @(negedge aclk); areset = 1'b1;
        @(negedge aclk); areset = 1'b0;
        exp_id = 16'd0; exp_frames = 16'd0;
    endtask

    task automatic run_packet(input int bp_pct, input int busy_at, input bit mutate, input int abort_at);
        int n, bubbles, unstable, tlast_err, mism;
        bit first, stalled, done, aborted;
        logic [7:0] pd;
        logic pl;
        n = 0; bubbles = 0; unstable = 0; tlast_err = 0; mism = 0;
        first = 1; stalled = 0; done = 0; aborted = 0; pd = 8'h00; pl = 1'b0;
        build_expected(exp_id);
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
        checks++;
        if (ready !== 1'b0 || tvalid !== 1'b0) begin
            failures++; $display("FAIL start_edge: ready=%b tvalid=%b want ready=0 tvalid=0", ready, tvalid);
        end
        @(negedge aclk);
        checks++;
        if (tvalid !== 1'b0) begin
            failures++; $display("FAIL early_valid: tvalid=%b want 0", tvalid);
        end
        for (int cyc = 0; cyc < 6000 && !done && !aborted; cyc++) begin
            @(negedge aclk);
            if (abort_at >= 0 && n == abort_at) begin
                areset = 1'b1;
                #1;
                checks++;
                if (tvalid !== 1'b0 || tlast !== 1'b0 || ready !== 1'b1 || frames !== 16'd0) begin
                    failures++;
                    $display("FAIL abort_reset: tvalid=%b tlast=%b ready=%b frames=%h want 0 0 1 0000",
                             tvalid, tlast, ready, frames);
                end
                @(negedge aclk); areset = 1'b0; tready = 1'b1;
                exp_id = 16'd0; exp_frames = 16'd0;
                aborted = 1;
            end else begin
                if (first) begin
                    checks++;
                    if (tvalid !== 1'b1) begin
                        failures++; $display("FAIL latency: tvalid=%b two cycles after start, want 1", tvalid);
                    end
                    first = 0;
                end else if (tvalid !== 1'b1) begin
                    bubbles++;
                end
                if (stalled && (tdata !== pd || tlast !== pl)) unstable++;
                start = (busy_at >= 0 && n == busy_at);
                if (mutate && n == busy_at) randomize_inputs();
                tready = ($urandom_range(99) < bp_pct);
                stalled = tvalid && !tready; pd = tdata; pl = tlast;
                if (tvalid && tready) begin
                    cap[n] = tdata;
                    if (tlast !== (n == NB - 1)) tlast_err++;
                    n++;
                    if (n == NB) done = 1;
                end
            end
        end
        start = 1'b0;
        if (!aborted) begin
            for (int i = 0; i < NB; i++) if (i < n && cap[i] !== exp_b[i]) mism++;
            checks++;
            if (n != NB) begin failures++; $display("FAIL beat_count: got %0d beats want %0d", n, NB); end
            checks++;
            if (mism != 0) begin failures++; $display("FAIL packet_bytes: %0d mismatched bytes want 0", mism); end
            checks++;
            if (tlast_err != 0) begin failures++; $display("FAIL tlast_pos: %0d bad tlast beats want 0", tlast_err); end
            checks++;
            if (bubbles != 0) begin failures++; $display("FAIL tvalid_bubble: %0d gaps want 0", bubbles); end
            checks++;
            if (unstable != 0) begin failures++; $display("FAIL stall_stable: %0d changes want 0", unstable); end
            tready = 1'b1;
            @(negedge aclk);
            exp_frames = exp_frames + 16'd1;
            exp_id = exp_id + 16'd1;
            checks++;
            if (tvalid !== 1'b0 || tlast !== 1'b0 || ready !== 1'b1 || frames !== exp_frames) begin
                failures++;
                $display("FAIL end_of_packet: tvalid=%b tlast=%b ready=%b frames=%h want 0 0 1 %h",
                         tvalid, tlast, ready, frames, exp_frames);
            end
            @(negedge aclk);
            checks++;
            if (ready !== 1'b1 || tvalid !== 1'b0) begin
                failures++; $display("FAIL no_queue: ready=%b tvalid=%b want 1 0", ready, tvalid);
            end
        end
    endtask

    task automatic set_defaults();
        randomize_inputs();
        src_ip = 32'hC0A8010A; dst_ip = 32'hC0A80114;
    endtask

    task automatic test_reset();
        checks++;
        if (ready !== 1'b1 || tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00 || frames !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b tvalid=%b tlast=%b tdata=%h frames=%h want 1 0 0 00 0000",
                     ready, tvalid, tlast, tdata, frames);
        end
    endtask

    task automatic test_default_header();
        logic [7:0] fixed [0:9];
        logic [7:0] ipb [0:7];
        int bad;
        set_defaults();
        saved_frame = data_frame; saved_smac = src_mac; saved_dmac = dst_mac;
        run_packet(100, -1, 0, -1);
        fixed = '{8'h45, 8'h00, 8'h03, 8'h25, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'hFD};
        ipb   = '{8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h14};
        bad = 0;
        for (int i = 0; i < 10; i++) if (cap[14+i] !== fixed[i]) bad++;
        for (int i = 0; i < 8; i++) if (cap[26+i] !== ipb[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL default_hdr: %0d bytes differ from table want 0", bad); end
        checks++;
        if ({cap[24], cap[25]} !== {exp_b[24], exp_b[25]}) begin
            failures++; $display("FAIL default_csum: got %h%h want %h%h", cap[24], cap[25], exp_b[24], exp_b[25]);
        end
        for (int i = 0; i < NB; i++) ref_pkt[i] = cap[i];
    endtask

    task automatic test_mac_payload();
        logic [7:0] macb [0:13];
        int bad;
        randomize_inputs();
        dst_mac = 48'h001122334455; src_mac = 48'hAABBCCDDEEFF;
        for (int k = 0; k < PB; k++) data_frame[8*k +: 8] = 8'(k % 256);
        run_packet(100, -1, 0, -1);
        macb = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h08, 8'h00};
        bad = 0;
        for (int i = 0; i < 14; i++) if (cap[i] !== macb[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mac_order: %0d bytes wrong want 0", bad); end
        bad = 0;
        for (int k = 0; k < PB; k++) if (cap[34+k] !== 8'(k % 256)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL payload_order: %0d bytes wrong want 0", bad); end
    endtask

    task automatic test_backpressure();
        randomize_inputs();
        run_packet(50, 400, 1, -1);
        randomize_inputs();
        run_packet(30, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] cs1;
        pulse_reset();
        set_defaults();
        run_packet(100, 300, 0, -1);
        cs1 = {cap[24], cap[25]};
        run_packet(100, -1, 0, -1);
        checks++;
        if ({cap[18], cap[19]} !== 16'h0001) begin
            failures++; $display("FAIL b2b_id: got %h%h want 0001", cap[18], cap[19]);
        end
        checks++;
        if ({cap[24], cap[25]} !== cs1 - 16'd1) begin
            failures++; $display("FAIL b2b_csum: got %h%h want %h", cap[24], cap[25], cs1 - 16'd1);
        end
        checks++;
        if (frames !== 16'd2) begin failures++; $display("FAIL b2b_frames: got %h want 0002", frames); end
    endtask

    task automatic test_reset_mid();
        int bad;
        randomize_inputs();
        run_packet(100, -1, 0, 100);
        src_ip = 32'hC0A8010A; dst_ip = 32'hC0A80114;
        src_mac = saved_smac; dst_mac = saved_dmac; data_frame = saved_frame;
        run_packet(100, -1, 0, -1);
        bad = 0;
        for (int i = 0; i < NB; i++) if (cap[i] !== ref_pkt[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL after_abort: %0d bytes differ from first packet want 0", bad); end
    endtask

    task automatic test_wrap();
        @(negedge aclk);
        force dut.frames_q = 16'hFFFF;
        force dut.ip_id_q  = 16'hFFFF;
        @(negedge aclk);
        @(negedge aclk);
        release dut.frames_q;
        release dut.ip_id_q;
        exp_frames = 16'hFFFF; exp_id = 16'hFFFF;
        @(negedge aclk);
        randomize_inputs();
        run_packet(100, -1, 0, -1);
        checks++;
        if ({cap[18], cap[19]} !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_id_top: got %h%h want FFFF", cap[18], cap[19]);
        end
        checks++;
        if (frames !== 16'h0000 || $isunknown(frames)) begin
            failures++; $display("FAIL wrap_frames: got %h want 0000", frames);
        end
        run_packet(100, -1, 0, -1);
        checks++;
        if ({cap[18], cap[19]} !== 16'h0000) begin
            failures++; $display("FAIL wrap_id_zero: got %h%h want 0000", cap[18], cap[19]);
        end
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; tready = 1'b1;
        src_ip = '0; dst_ip = '0; src_mac = '0; dst_mac = '0; data_frame = '0;
        repeat (3) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0; areset = 1'b0;
        @(negedge aclk);
        test_reset();
        test_default_header();
        test_mac_payload();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
